// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor, DIGIT bits per cycle LSB-first with registered carry.
// Define SERIAL_ADDSUB_SEXT_EN to add a sign-extended immediate alternative for operand B.
module serial_addsub #(
  parameter int WIDTH     = 32,
  parameter int DIGIT     = 1,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sub,
`ifdef SERIAL_ADDSUB_SEXT_EN
  input  logic                 use_imm,
  input  logic [IMM_WIDTH-1:0] b_imm,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic                 zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0 || IMM_WIDTH >= WIDTH) begin : g_bad_cfg
    $error("serial_addsub: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [WIDTH-1:0]  b_sel;
  logic [DIGIT:0]    dsum;
  logic              cin_msb;
  logic              last;
  logic [WIDTH-1:0]  a_shift;

  // Sum digits enter the A shift register from the top as A's digits leave the bottom,
  // so after N steps a_q holds the full result.
  always_comb begin
    b_sel = b;
`ifdef SERIAL_ADDSUB_SEXT_EN
    if (use_imm) b_sel = {{(WIDTH-IMM_WIDTH){b_imm[IMM_WIDTH-1]}}, b_imm};
`endif
    dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    cin_msb = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    last    = (cnt_q == CW'(N-1));
    a_shift = (a_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH-DIGIT));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b_sel : b_sel;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_shift;
        b_d     = b_q >> DIGIT;
        carry_d = dsum[DIGIT];
        cnt_d   = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          result_d = a_shift;
          cout_d   = dsum[DIGIT];
          ovf_d    = cin_msb ^ dsum[DIGIT];
          zero_d   = (a_shift == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: a DIGIT=1 instance and a DIGIT=4 instance, both 32 bits wide.
`timescale 1ns/1ps
module tb_serial_addsub;

  logic        clk, rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow, zero;
  logic [31:0] a, b, result;
  logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, carry_out4, overflow4, zero4;
  logic [31:0] a4, b4, result4;
`ifdef SERIAL_ADDSUB_SEXT_EN
  logic        use_imm, use_imm4;
  logic [15:0] b_imm, b_imm4;
`endif

  int checks   = 0;
  int failures = 0;

  serial_addsub #(.WIDTH(32), .DIGIT(1), .IMM_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
`ifdef SERIAL_ADDSUB_SEXT_EN
    .use_imm(use_imm), .b_imm(b_imm),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  serial_addsub #(.WIDTH(32), .DIGIT(4), .IMM_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .sub(sub4),
`ifdef SERIAL_ADDSUB_SEXT_EN
    .use_imm(use_imm4), .b_imm(b_imm4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .carry_out(carry_out4), .overflow(overflow4), .zero(zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic. Returns {carry_out, overflow, zero, result}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint ux, uy, sx, sy, ur, sr;
    logic   c, o;
    ux = {32'b0, x};
    uy = {32'b0, y};
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);
    end else begin
      ur = ux + uy;
      sr = sx + sy;
      c  = (ur > 64'sd4294967295);
    end
    o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {c, o, (ur[31:0] == 32'd0), ur[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                        output logic [34:0] got, output int lat);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    a = ia; b = ib; sub = is; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    got = {carry_out, overflow, zero, result};
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic run_op4(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         output logic [34:0] got, output int lat);
    int guard = 0;
    while (in_ready4 !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    a4 = ia; b4 = ib; sub4 = is; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = $urandom; b4 = $urandom; sub4 = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDSUB_SEXT_EN
    use_imm4 = ~use_imm4; b_imm4 = 16'($urandom);
`endif
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    got = {carry_out4, overflow4, zero4, result4};
    out_ready4 = 1'b1; @(posedge clk); #1; out_ready4 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    checks++;
    if ({carry_out, overflow, zero, result} !== 35'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", {carry_out, overflow, zero, result});
    end
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || {carry_out4, overflow4, zero4, result4} !== 35'd0) begin
      failures++; $display("FAIL reset_dut4: in_ready=%b out_valid=%b outs=%h expected 1/0/0",
                           in_ready4, out_valid4, {carry_out4, overflow4, zero4, result4});
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [31:0] ta[5]  = '{32'd5, 32'd3, 32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tb_[5] = '{32'd3, 32'd5, 32'd5, 32'd1, 32'd1};
    logic        ts[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [34:0] te[5]  = '{{3'b000, 32'd8}, {3'b000, 32'hFFFF_FFFE}, {3'b101, 32'd0},
                           {3'b010, 32'h8000_0000}, {3'b101, 32'd0}};
    logic [34:0] got;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb_[i], ts[i], got, lat);
      checks++;
      if (got !== te[i]) begin
        failures++; $display("FAIL directed_%0d: got {c,o,z,res}=%h expected %h", i, got, te[i]);
      end
      checks++;
      if (lat !== 32) begin
        failures++; $display("FAIL directed_latency_%0d: got %0d expected 32", i, lat);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++; $display("FAIL directed_idle_%0d: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] x, y;
    logic        s;
    logic [34:0] got, exp;
    int          lat;
    for (int i = 0; i < 25; i++) begin
      x = pick(); y = pick(); s = 1'($urandom_range(0, 1));
      exp = model(x, y, s);
      run_op(x, y, s, got, lat);
      checks++;
      if (got !== exp || lat !== 32) begin
        failures++; $display("FAIL random_%0d: a=%h b=%h sub=%b got %h lat %0d expected %h lat 32",
                             i, x, y, s, got, lat, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int          guard = 0;
    int          bad = 0;
    logic [34:0] got;
    while (in_ready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    a = 32'd100; b = 32'd23; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    a = 32'd777; b = 32'd1; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {carry_out, overflow, zero, result} !== {3'b000, 32'd123}) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL stall_hold: %0d bad cycles, last out=%h expected 0 bad cycles holding %h",
                           bad, {carry_out, overflow, zero, result}, {3'b000, 32'd123});
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd123) begin
      failures++; $display("FAIL stall_release: in_ready=%b out_valid=%b result=%h expected 1/0/0000007b",
                           in_ready, out_valid, result);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL stall_next_accept: in_ready=%b expected 0", in_ready);
    end
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    got = {carry_out, overflow, zero, result};
    checks++;
    if (got !== model(32'd777, 32'd1, 1'b1) || guard !== 32) begin
      failures++; $display("FAIL stall_next_op: got %h lat %0d expected %h lat 32", got, guard, model(32'd777, 32'd1, 1'b1));
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun;
    int          guard = 0;
    int          seen = 0;
    logic [34:0] got;
    int          lat;
    while (in_ready !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    a = 32'd9; b = 32'd9; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
      failures++; $display("FAIL midrun_reset: in_ready=%b out_valid=%b result=%h expected 1/0/0", in_ready, out_valid, result);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL midrun_discard: %0d cycles left idle expected 0", seen);
    end
    run_op(32'd1, 32'd2, 1'b0, got, lat);
    checks++;
    if (got !== {3'b000, 32'd3} || lat !== 32) begin
      failures++; $display("FAIL midrun_next_op: got %h lat %0d expected %h lat 32", got, lat, {3'b000, 32'd3});
    end
  endtask

  task automatic test_digit4;
    logic [31:0] x, y;
    logic        s;
    logic [34:0] got, exp;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      x = pick(); y = pick(); s = 1'($urandom_range(0, 1));
      exp = model(x, y, s);
      run_op4(x, y, s, got, lat);
      checks++;
      if (got !== exp || lat !== 8) begin
        failures++; $display("FAIL digit4_%0d: a=%h b=%h sub=%b got %h lat %0d expected %h lat 8",
                             i, x, y, s, got, lat, exp);
      end
    end
  endtask

`ifdef SERIAL_ADDSUB_SEXT_EN
  task automatic test_sext;
    logic [34:0] got, exp;
    logic [31:0] x, y;
    logic [15:0] imm;
    logic        s;
    int          lat;
    use_imm4 = 1'b1; b_imm4 = 16'h8000;
    run_op4(32'd0, 32'h1234_5678, 1'b0, got, lat);
    checks++;
    if (got[31:0] !== 32'hFFFF_8000 || lat !== 8) begin
      failures++; $display("FAIL sext_neg: got %h lat %0d expected ffff8000 lat 8", got[31:0], lat);
    end
    for (int i = 0; i < 6; i++) begin
      x = pick(); y = pick(); imm = 16'($urandom); s = 1'($urandom_range(0, 1));
      use_imm4 = 1'(i % 2); b_imm4 = imm;
      exp = model(x, use_imm4 ? {{16{imm[15]}}, imm} : y, s);
      run_op4(x, y, s, got, lat);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL sext_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; out_ready4 = 1'b0;
`ifdef SERIAL_ADDSUB_SEXT_EN
    use_imm = 1'b0; b_imm = '0; use_imm4 = 1'b0; b_imm4 = '0;
`endif
    #2;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_digit4();
`ifdef SERIAL_ADDSUB_SEXT_EN
    test_sext();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
